// File: rtl/rsa_spi_regbank.sv
// rsa_spi_regbank: oversampled SPI mode-0 slave register bank with busy/done/err status and irq for a modular-arithmetic core
module rsa_spi_regbank #(
  parameter int WIDTH = 8,
  parameter int NUM_OPS = 4,
  parameter int ADDR_W = 3
) (
  input  logic                     clk,
  input  logic                     rstb,
  input  logic                     ena,
  input  logic                     spi_cs_n,
  input  logic                     spi_clk,
  input  logic                     spi_mosi,
  output logic                     spi_miso,
  output logic                     start_pulse,
  output logic                     stop_pulse,
  output logic [NUM_OPS*WIDTH-1:0] operands,
  input  logic [WIDTH-1:0]         result,
  input  logic                     eoc,
  output logic                     irq,
  output logic [WIDTH-1:0]         spare
);
  localparam int CW = $clog2(WIDTH);
  localparam int A_RES = NUM_OPS + 2;
  localparam int A_SPARE = NUM_OPS + 3;
  typedef enum logic [1:0] {IDLE, CMD, DATA, DONE} state_t;
  state_t state;
  logic [2:0] cs_s, sclk_s;
  logic [1:0] mosi_s;
  logic [CW-1:0] cnt;
  logic [WIDTH-2:0] rx;
  logic [WIDTH-1:0] tx, res_q, rd_data, wdata;
  logic [ADDR_W-1:0] addr;
  logic cmd_wr, ld, busy, done, err, irq_en, pend_start, pend_stop;
  logic rise, fall, cs_fall, wr, ctrl_wr, stat_wr, op_wr, go;
  assign rise = sclk_s[1] & ~sclk_s[2];
  assign fall = ~sclk_s[1] & sclk_s[2];
  assign cs_fall = cs_s[2] & ~cs_s[1];
  assign wdata = {rx, mosi_s[1]};
  assign wr = ena & ~cs_s[1] & (state == DATA) & rise & (cnt == CW'(WIDTH - 1)) & cmd_wr;
  assign stat_wr = wr & (addr == ADDR_W'(0));
  assign ctrl_wr = wr & (addr == ADDR_W'(1));
  assign op_wr = wr & (int'(addr) >= 2) & (int'(addr) <= NUM_OPS + 1);
  assign go = pend_start & ~pend_stop & ~busy;
  always_comb begin
    rd_data = '0;
    if (addr == ADDR_W'(0)) rd_data[3:0] = {irq_en, err, done, busy};
    if (addr == ADDR_W'(1)) rd_data[2] = irq_en;
    if (addr == ADDR_W'(A_RES)) rd_data = res_q;
    if (addr == ADDR_W'(A_SPARE)) rd_data = spare;
    for (int k = 0; k < NUM_OPS; k++)
      if (addr == ADDR_W'(k + 2)) rd_data = operands[k*WIDTH +: WIDTH];
  end
  always_ff @(posedge clk or negedge rstb)
    if (!rstb) begin
      cs_s <= '1;
      sclk_s <= '0;
      mosi_s <= '0;
    end else begin
      cs_s <= {cs_s[1:0], spi_cs_n};
      sclk_s <= {sclk_s[1:0], spi_clk};
      mosi_s <= {mosi_s[0], spi_mosi};
    end
  // Disabling drops the FSM to IDLE so a frame can only restart on a fresh cs_n fall.
  always_ff @(posedge clk or negedge rstb)
    if (!rstb) begin
      state <= IDLE;
      cnt <= '0;
      rx <= '0;
      tx <= '0;
      addr <= '0;
      cmd_wr <= 1'b0;
      ld <= 1'b0;
      spi_miso <= 1'b0;
    end else if (!ena || cs_s[1]) begin
      state <= IDLE;
      ld <= 1'b0;
      spi_miso <= 1'b0;
    end else begin
      ld <= 1'b0;
      spi_miso <= (state == DATA && !ld) ? tx[WIDTH-1] : 1'b0;
      if (ld) tx <= rd_data;
      else if (fall && state == DATA && cnt != '0) tx <= {tx[WIDTH-2:0], 1'b0};
      if (state == IDLE && cs_fall) begin
        state <= CMD;
        cnt <= '0;
      end else if (rise && state == CMD) begin
        rx <= wdata[WIDTH-2:0];
        cnt <= (cnt == CW'(7)) ? '0 : cnt + 1'b1;
        if (cnt == CW'(7)) begin
          state <= DATA;
          cmd_wr <= wdata[7];
          addr <= wdata[ADDR_W-1:0];
          ld <= 1'b1;
        end
      end else if (rise && state == DATA) begin
        rx <= wdata[WIDTH-2:0];
        cnt <= cnt + 1'b1;
        if (cnt == CW'(WIDTH - 1)) state <= DONE;
      end
    end
  always_ff @(posedge clk or negedge rstb)
    if (!rstb) begin
      operands <= '0;
      spare <= '0;
      res_q <= '0;
      {busy, done, err, irq_en, pend_start, pend_stop, start_pulse, stop_pulse, irq} <= '0;
    end else if (!ena) begin
      start_pulse <= 1'b0;
      stop_pulse <= 1'b0;
    end else begin
      pend_start <= ctrl_wr & wdata[0];
      pend_stop <= ctrl_wr & wdata[1];
      start_pulse <= go;
      stop_pulse <= pend_stop;
      busy <= ~pend_stop & (busy ? ~eoc : pend_start);
      done <= (eoc & busy) | (done & ~go & ~(stat_wr & wdata[1]));
      err <= (op_wr & busy) | (err & ~(stat_wr & wdata[2]));
      irq <= done & irq_en;
      if (eoc && busy) res_q <= result;
      if (ctrl_wr) irq_en <= wdata[2];
      if (wr && addr == ADDR_W'(A_SPARE)) spare <= wdata;
      for (int k = 0; k < NUM_OPS; k++)
        if (op_wr && !busy && addr == ADDR_W'(k + 2)) operands[k*WIDTH +: WIDTH] <= wdata;
    end
endmodule

// File: tb/tb_rsa_spi_regbank.sv
// tb_rsa_spi_regbank: randomized SPI traffic checked against a register-map level model of the bank
module tb_rsa_spi_regbank;
  logic clk = 0, rstb = 0, ena = 1, spi_cs_n = 1, spi_clk = 0, spi_mosi = 0, eoc = 0;
  logic [7:0] result = 0;
  logic spi_miso, start_pulse, stop_pulse, irq;
  logic [31:0] operands;
  logic [7:0] spare;
  int n_checks = 0, n_errors = 0, n_start = 0, n_stop = 0, m_nstart = 0, m_nstop = 0;
  logic chk_en = 0;
  logic [7:0] m_ops [4];
  logic [7:0] m_res, m_spare;
  logic m_busy, m_done, m_err, m_irqen;

  rsa_spi_regbank #(.WIDTH(8), .NUM_OPS(4), .ADDR_W(3)) dut (
    .clk(clk), .rstb(rstb), .ena(ena), .spi_cs_n(spi_cs_n), .spi_clk(spi_clk),
    .spi_mosi(spi_mosi), .spi_miso(spi_miso), .start_pulse(start_pulse),
    .stop_pulse(stop_pulse), .operands(operands), .result(result), .eoc(eoc),
    .irq(irq), .spare(spare)
  );

  always #5 clk = ~clk;

  task automatic check(input string nm, input logic [31:0] act, input logic [31:0] exp);
    n_checks++;
    if (act !== exp) begin
      n_errors++;
      $display("FAIL %s: got %0h expected %0h at %0t", nm, act, exp, $time);
    end
  endtask

  task automatic model_reset();
    for (int i = 0; i < 4; i++) m_ops[i] = 0;
    m_res = 0; m_spare = 0; m_busy = 0; m_done = 0; m_err = 0; m_irqen = 0;
  endtask

  function automatic logic [7:0] m_read(input int a);
    if (a == 0) return {4'b0, m_irqen, m_err, m_done, m_busy};
    if (a == 1) return {5'b0, m_irqen, 2'b0};
    if (a >= 2 && a <= 5) return m_ops[a-2];
    if (a == 6) return m_res;
    return m_spare;
  endfunction

  task automatic model_wr(input int a, input logic [7:0] d);
    if (a == 0) begin
      if (d[1]) m_done = 0;
      if (d[2]) m_err = 0;
    end else if (a == 1) begin
      m_irqen = d[2];
      if (d[1]) begin m_busy = 0; m_nstop++; end
      else if (d[0] && !m_busy) begin m_busy = 1; m_done = 0; m_nstart++; end
    end else if (a >= 2 && a <= 5) begin
      if (m_busy) m_err = 1; else m_ops[a-2] = d;
    end else if (a == 7) m_spare = d;
  endtask

  always @(negedge clk) begin
    if (start_pulse) n_start++;
    if (stop_pulse) n_stop++;
  end

  always @(negedge clk) if (chk_en && rstb) begin
    check("operands", operands, {m_ops[3], m_ops[2], m_ops[1], m_ops[0]});
    check("spare", 32'(spare), 32'(m_spare));
    check("irq", 32'(irq), 32'(m_done & m_irqen));
    check("start_idle", 32'(start_pulse), 32'd0);
    check("stop_idle", 32'(stop_pulse), 32'd0);
    check("miso_idle", 32'(spi_miso), 32'd0);
  end

  task automatic bit_x(input logic m, output logic s);
    spi_mosi = m;
    repeat (8) @(negedge clk);
    s = spi_miso;
    spi_clk = 1;
    repeat (8) @(negedge clk);
    spi_clk = 0;
  endtask

  task automatic spi_xfer(input logic [7:0] c, input logic [7:0] d, input int nd, output logic [7:0] q);
    logic b;
    chk_en = 0;
    q = 0;
    @(negedge clk);
    spi_cs_n = 0;
    repeat (6) @(negedge clk);
    for (int i = 7; i >= 0; i--) bit_x(c[i], b);
    for (int i = 0; i < nd; i++) begin
      bit_x(d[7-i], b);
      q = {q[6:0], b};
    end
    repeat (4) @(negedge clk);
    spi_cs_n = 1;
    repeat (6) @(negedge clk);
  endtask

  task automatic do_wr(input int a, input logic [7:0] d);
    logic [7:0] q;
    spi_xfer({1'b1, 4'($urandom), 3'(a)}, d, 8, q);
    model_wr(a, d);
    if (a == 1) begin
      check("start_count", 32'(n_start), 32'(m_nstart));
      check("stop_count", 32'(n_stop), 32'(m_nstop));
    end
    chk_en = 1;
  endtask

  task automatic do_rd(input int a, input logic [7:0] exp, input string nm);
    logic [7:0] q;
    spi_xfer({1'b0, 4'($urandom), 3'(a)}, 8'($urandom), 8, q);
    check(nm, 32'(q), 32'(exp));
    chk_en = 1;
  endtask

  task automatic do_eoc(input logic [7:0] r);
    chk_en = 0;
    @(negedge clk);
    result = r;
    eoc = 1;
    @(negedge clk);
    eoc = 0;
    repeat (3) @(negedge clk);
    if (ena && m_busy) begin m_res = r; m_busy = 0; m_done = 1; end
    chk_en = ena;
  endtask

  initial begin
    logic [7:0] q;
    logic b;
    logic [7:0] c;
    model_reset();
    repeat (3) @(negedge clk);
    check("rst_miso", 32'(spi_miso), 0);
    check("rst_irq", 32'(irq), 0);
    check("rst_ops", operands, 0);
    rstb = 1;
    repeat (3) @(negedge clk);
    chk_en = 1;
    for (int a = 0; a < 8; a++) do_rd(a, 8'h00, "reset_read");
    do_wr(2, 8'h3D);
    do_wr(7, 8'hA5);
    check("op0_lit", 32'(operands[7:0]), 32'h3D);
    check("spare_lit", 32'(spare), 32'hA5);
    do_rd(2, 8'h3D, "read_op0");
    do_rd(7, 8'hA5, "read_spare");
    do_wr(1, 8'h05);
    check("start_lit", 32'(n_start), 32'd1);
    do_rd(0, 8'h09, "status_busy");
    chk_en = 0;
    @(negedge clk);
    result = 8'h5C;
    eoc = 1;
    @(negedge clk);
    eoc = 0;
    check("irq_lag", 32'(irq), 0);
    @(negedge clk);
    check("irq_set", 32'(irq), 1);
    repeat (2) @(negedge clk);
    m_res = 8'h5C; m_busy = 0; m_done = 1;
    chk_en = 1;
    do_rd(0, 8'h0A, "status_done");
    do_rd(6, 8'h5C, "read_result");
    do_wr(1, 8'h05);
    do_wr(3, 8'h11);
    check("op1_kept", 32'(operands[15:8]), 0);
    do_rd(0, 8'h0D, "status_err");
    do_wr(0, 8'h06);
    do_rd(0, 8'h09, "status_w1c");
    check("irq_clear", 32'(irq), 0);
    do_eoc(8'h77);
    do_wr(0, 8'h02);
    do_wr(1, 8'h03);
    check("stop_only_start", 32'(n_start), 32'd2);
    check("stop_only_stop", 32'(n_stop), 32'd1);
    do_rd(0, 8'h00, "status_stopped");
    do_wr(1, 8'h01);
    do_wr(1, 8'h01);
    check("no_restart", 32'(n_start), 32'd3);
    do_rd(0, 8'h01, "status_busy2");
    spi_xfer({1'b1, 4'b0, 3'd4}, 8'hF0, 4, q);
    chk_en = 1;
    do_rd(4, m_read(4), "partial_frame");
    chk_en = 0;
    @(negedge clk);
    spi_cs_n = 0;
    repeat (6) @(negedge clk);
    c = 8'h85;
    for (int i = 7; i >= 0; i--) bit_x(c[i], b);
    ena = 0;
    for (int i = 0; i < 4; i++) bit_x(1'b1, b);
    do_eoc(8'h99);
    ena = 1;
    for (int i = 7; i >= 0; i--) bit_x(c[i], b);
    for (int i = 0; i < 8; i++) bit_x(1'b1, b);
    repeat (4) @(negedge clk);
    spi_cs_n = 1;
    repeat (6) @(negedge clk);
    chk_en = 1;
    do_rd(5, 8'h00, "ena_no_write");
    do_rd(0, 8'h01, "ena_no_eoc");
    do_eoc(8'h99);
    do_wr(1, 8'h04);
    check("irq_before_rst", 32'(irq), 1);
    chk_en = 0;
    @(negedge clk);
    spi_cs_n = 0;
    repeat (6) @(negedge clk);
    for (int i = 0; i < 5; i++) bit_x(1'b1, b);
    rstb = 0;
    #1;
    check("rst_mid_ops", operands, 0);
    check("rst_mid_spare", 32'(spare), 0);
    check("rst_mid_irq", 32'(irq), 0);
    check("rst_mid_miso", 32'(spi_miso), 0);
    check("rst_mid_pulse", 32'({start_pulse, stop_pulse}), 0);
    model_reset();
    @(negedge clk);
    spi_cs_n = 1;
    repeat (3) @(negedge clk);
    rstb = 1;
    repeat (3) @(negedge clk);
    chk_en = 1;
    do_wr(4, 8'hC3);
    do_rd(4, 8'hC3, "after_rst");
    for (int n = 0; n < 70; n++) begin
      int op, a;
      op = $urandom_range(0, 9);
      a = $urandom_range(0, 7);
      if (op < 5) do_wr(a, 8'($urandom));
      else if (op < 8) do_rd(a, m_read(a), "rand_read");
      else do_eoc(8'($urandom));
    end
    chk_en = 0;
    $display("Simulation finished: %0d checks, %0d errors", n_checks, n_errors);
    $finish;
  end
endmodule
